// File: rtl/gpio_pwm_pkg.sv
// Register map for gpio_pwm_bank: word offsets decoded from mem_addr[7:2], STATUS fields, byte-lane merge.
// Constants and a pure function only; no latency and no flow control.
package gpio_pwm_pkg;

    localparam logic [5:0] OFS_OUT       = 6'h00;
    localparam logic [5:0] OFS_MODE      = 6'h01;
    localparam logic [5:0] OFS_PRESC     = 6'h02;
    localparam logic [5:0] OFS_STATUS    = 6'h03;
    localparam logic [5:0] OFS_DUTY_BASE = 6'h10;

    localparam int STATUS_WRAP_BIT = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_pwm_bank_pwm_timebase.sv
// Shared PWM timebase: prescaler down-counter plus PWM up-counter; tick/wrap are combinational from the counters.
// Tick asserts in the cycle the prescaler is 0; free-running, no backpressure.
module pwm_timebase #(
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESC_BITS-1:0] presc,
    output logic                  tick,
    output logic                  wrap,
    output logic [PWM_BITS-1:0]   pwm_cnt
);

    logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;

    // A new reload value is only picked up when the prescaler reaches 0.
    always_comb begin
        tick        = (presc_cnt_q == '0);
        wrap        = tick && (pwm_cnt_q == '1);
        presc_cnt_d = tick ? presc : presc_cnt_q - PRESC_BITS'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/gpio_pwm_bank.sv
// Memory-mapped GPIO/PWM output bank: register file, bus decode, read mux, per-channel duty compare.
// Writes land on the strobe edge, reads return one cycle after sel&rstrb; never busy, no backpressure.
module gpio_pwm_bank
    import gpio_pwm_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wmask,
    input  logic              mem_rstrb,
    output logic [31:0]       mem_rdata,
    output logic [NUM_CH-1:0] gpio_out
);

    logic [NUM_CH-1:0]     out_q, out_d;
    logic [NUM_CH-1:0]     mode_q, mode_d;
    logic [NUM_CH-1:0]     gpio_q, gpio_d;
    logic [NUM_CH-1:0]     pwm_lvl;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  wrap_q, wrap_d;
    logic [PWM_BITS-1:0]   duty_shadow_q [NUM_CH];
    logic [PWM_BITS-1:0]   duty_shadow_d [NUM_CH];
    logic [PWM_BITS-1:0]   active_duty_q [NUM_CH];
    logic [PWM_BITS-1:0]   active_duty_d [NUM_CH];
    logic [31:0]           rdata_q, rdata_d;

    logic [5:0]            word;
    logic [31:0]           reg_val;
    logic [31:0]           wr_val;
    logic                  wr_en;
    logic                  wrap_clr;
    logic                  tick;
    logic                  wrap;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  unused_ok;

    pwm_timebase #(
        .PWM_BITS   (PWM_BITS),
        .PRESC_BITS (PRESC_BITS)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .presc   (presc_q),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pwm_lvl[g] = (pwm_cnt < active_duty_q[g]);
    end

    // Current value of the addressed register; feeds both the read mux and the byte-lane merge.
    always_comb begin
        word    = mem_addr[7:2];
        reg_val = '0;
        case (word)
            OFS_OUT:    reg_val[NUM_CH-1:0]      = out_q;
            OFS_MODE:   reg_val[NUM_CH-1:0]      = mode_q;
            OFS_PRESC:  reg_val[PRESC_BITS-1:0]  = presc_q;
            OFS_STATUS: reg_val[STATUS_WRAP_BIT] = wrap_q;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (word == OFS_DUTY_BASE + 6'(i)) reg_val[PWM_BITS-1:0] = duty_shadow_q[i];
                end
            end
        endcase
    end

    always_comb begin
        wr_en         = sel && (mem_wmask != 4'h0);
        wr_val        = merge_bytes(reg_val, mem_wdata, mem_wmask);
        out_d         = out_q;
        mode_d        = mode_q;
        presc_d       = presc_q;
        duty_shadow_d = duty_shadow_q;
        wrap_clr      = 1'b0;
        if (wr_en) begin
            case (word)
                OFS_OUT:    out_d    = wr_val[NUM_CH-1:0];
                OFS_MODE:   mode_d   = wr_val[NUM_CH-1:0];
                OFS_PRESC:  presc_d  = wr_val[PRESC_BITS-1:0];
                OFS_STATUS: wrap_clr = mem_wmask[0] && mem_wdata[STATUS_WRAP_BIT];
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (word == OFS_DUTY_BASE + 6'(i)) duty_shadow_d[i] = wr_val[PWM_BITS-1:0];
                    end
                end
            endcase
        end

        // A wrap in the same cycle as a software clear must not be lost.
        wrap_d = wrap || (wrap_q && !wrap_clr);

        // Duties only change at the period boundary so no output ever sees a partial period.
        active_duty_d = active_duty_q;
        if (wrap) active_duty_d = duty_shadow_q;

        gpio_d  = (mode_q & pwm_lvl) | (~mode_q & out_q);
        rdata_d = (sel && mem_rstrb) ? reg_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q         <= '0;
            mode_q        <= '0;
            presc_q       <= '0;
            wrap_q        <= 1'b0;
            duty_shadow_q <= '{default: '0};
            active_duty_q <= '{default: '0};
            gpio_q        <= '0;
            rdata_q       <= '0;
        end else begin
            out_q         <= out_d;
            mode_q        <= mode_d;
            presc_q       <= presc_d;
            wrap_q        <= wrap_d;
            duty_shadow_q <= duty_shadow_d;
            active_duty_q <= active_duty_d;
            gpio_q        <= gpio_d;
            rdata_q       <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign gpio_out  = gpio_q;
    assign unused_ok = &{1'b0, mem_addr[31:8], mem_addr[1:0], wr_val, tick};

endmodule

// File: tb/tb_gpio_pwm_bank.sv
// Scoreboard bench for gpio_pwm_bank: stimulus queues expectations, a monitor pops and compares.
module tb_gpio_pwm_bank;

    localparam int NUM_CH = 5;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } item_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              sel;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata;
    logic [NUM_CH-1:0] gpio_out;

    logic  rd_vld = 1'b0;
    item_t rd_exp_q[$];
    item_t gpio_exp_q[$];
    item_t meas_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    highs;
    int    len;

    gpio_pwm_bank #(
        .NUM_CH     (NUM_CH),
        .PWM_BITS   (8),
        .PRESC_BITS (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .gpio_out  (gpio_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_vld <= sel && mem_rstrb;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read data when the bus presents it, gpio snapshots and period measurements on request.
    always begin
        item_t it;
        @(negedge clk);
        #1;
        if (rd_vld) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h with no expectation queued", mem_rdata);
            end else begin
                it = rd_exp_q.pop_front();
                compare(it.name, mem_rdata, it.exp);
            end
        end
        while (gpio_exp_q.size() > 0) begin
            it = gpio_exp_q.pop_front();
            compare(it.name, 32'(gpio_out), it.exp);
        end
        while (meas_q.size() > 0) begin
            it = meas_q.pop_front();
            compare(it.name, it.act, it.exp);
        end
    end

    task automatic expect_gpio(input string name, input logic [31:0] exp);
        gpio_exp_q.push_back('{name: name, act: 32'h0, exp: exp});
    endtask

    task automatic meas(input string name, input logic [31:0] act, input logic [31:0] exp);
        meas_q.push_back('{name: name, act: act, exp: exp});
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        sel       = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = mask;
        @(negedge clk);
        sel       = 1'b0;
        mem_wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        sel       = 1'b1;
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        rd_exp_q.push_back('{name: name, act: 32'h0, exp: exp});
        @(negedge clk);
        sel       = 1'b0;
        mem_rstrb = 1'b0;
    endtask

    task automatic bus_rw(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input logic [31:0] exp, input string name);
        sel       = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = mask;
        mem_rstrb = 1'b1;
        rd_exp_q.push_back('{name: name, act: 32'h0, exp: exp});
        @(negedge clk);
        sel       = 1'b0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
    endtask

    task automatic wait_rise(input int ch);
        logic prev;
        bit   got;
        got  = 1'b0;
        prev = gpio_out[ch];
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (!prev && gpio_out[ch]) got = 1'b1;
            prev = gpio_out[ch];
        end
        if (!got) meas($sformatf("rise_timeout_ch%0d", ch), 32'd0, 32'd1);
    endtask

    // Called on the negedge where a rising edge was just seen; stops at the next rising edge.
    task automatic count_to_rise(input int ch, output int h, output int l);
        logic prev;
        bit   got;
        got  = 1'b0;
        prev = gpio_out[ch];
        h    = int'(prev);
        l    = 1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (!prev && gpio_out[ch]) begin
                got = 1'b1;
            end else begin
                l++;
                h += int'(gpio_out[ch]);
            end
            prev = gpio_out[ch];
        end
        if (!got) meas($sformatf("period_timeout_ch%0d", ch), 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        sel       = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        expect_gpio("rst_gpio", 32'h0);
        bus_read(32'h00, 32'h0, "rst_out");
        bus_read(32'h04, 32'h0, "rst_mode");
        bus_read(32'h08, 32'h0, "rst_presc");
        bus_read(32'h0C, 32'h0, "rst_status");
        for (int i = 0; i < NUM_CH; i++) bus_read(32'h40 + 32'(4 * i), 32'h0, $sformatf("rst_duty%0d", i));

        // Static output: not visible the cycle after the write edge, visible one cycle later.
        bus_write(32'h00, 32'h15, 4'h1);
        expect_gpio("out_gpio_old", 32'h00);
        @(negedge clk);
        expect_gpio("out_gpio_new", 32'h15);
        bus_read(32'h00, 32'h15, "out_read");

        // Byte-lane masking, sel=0, wmask=0, unmapped offsets.
        bus_write(32'h00, 32'hFFFF_FF0A, 4'b1110);
        bus_read(32'h00, 32'h15, "out_lane0_masked");
        sel = 1'b0; mem_addr = 32'h00; mem_wdata = 32'h0; mem_wmask = 4'h1;
        @(negedge clk);
        mem_wmask = 4'h0;
        bus_write(32'h00, 32'h0, 4'h0);
        bus_read(32'h00, 32'h15, "out_nosel_nomask");
        bus_write(32'h04, 32'hFFFF_FFFF, 4'h0);
        bus_read(32'h04, 32'h0, "mode_nomask");
        bus_write(32'h30, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h30, 32'h0, "unmapped_0x30");
        bus_write(32'h54, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h54, 32'h0, "unmapped_duty5");

        // Same-cycle read and write returns the old value.
        bus_rw(32'h00, 32'h0A, 4'h1, 32'h15, "rw_old_value");
        @(negedge clk);
        expect_gpio("rw_gpio", 32'h0A);
        bus_read(32'h00, 32'h0A, "rw_new_value");

        // PWM set-up with PRESC=0.
        bus_write(32'h40, 32'd64, 4'h1);
        bus_write(32'h44, 32'd64, 4'h1);
        bus_write(32'h48, 32'h1FF, 4'hF);
        bus_write(32'h4C, 32'd0, 4'h1);
        bus_write(32'h00, 32'h10, 4'h1);
        bus_write(32'h04, 32'h0F, 4'h1);
        bus_read(32'h48, 32'hFF, "duty2_truncated");

        wait_rise(0);
        count_to_rise(0, highs, len);
        meas("ch0_d64_highs", 32'(highs), 32'd64);
        meas("ch0_d64_period", 32'(len), 32'd256);

        // Duty change mid-period takes effect only from the next period.
        wait_rise(1);
        fork
            count_to_rise(1, highs, len);
            begin
                repeat (100) @(negedge clk);
                bus_write(32'h44, 32'd192, 4'h1);
            end
        join
        meas("ch1_cur_period_highs", 32'(highs), 32'd64);
        meas("ch1_cur_period_len", 32'(len), 32'd256);
        count_to_rise(1, highs, len);
        meas("ch1_next_period_highs", 32'(highs), 32'd192);
        meas("ch1_next_period_len", 32'(len), 32'd256);

        wait_rise(2);
        count_to_rise(2, highs, len);
        meas("ch2_d255_highs", 32'(highs), 32'd255);
        meas("ch2_d255_period", 32'(len), 32'd256);

        highs = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            highs += int'(gpio_out[3]);
        end
        meas("ch3_d0_highs", 32'(highs), 32'd0);
        bus_read(32'h0C, 32'h1, "status_wrap_set");

        // Prescaler 3: tick every 4 cycles, period 1024.
        bus_write(32'h08, 32'd3, 4'h3);
        bus_read(32'h08, 32'd3, "presc_read");
        wait_rise(0);
        count_to_rise(0, highs, len);
        meas("presc3_highs", 32'(highs), 32'd256);
        meas("presc3_period", 32'(len), 32'd1024);
        bus_write(32'h0C, 32'h1, 4'h1);
        bus_read(32'h0C, 32'h0, "status_cleared");

        // Rise is seen one cycle after the wrap edge, so the next wrap edge is 1023 cycles on.
        wait_rise(0);
        repeat (1022) @(negedge clk);
        bus_write(32'h0C, 32'h1, 4'h1);
        bus_read(32'h0C, 32'h1, "status_set_beats_clear");

        // Reset in the middle of a period.
        reset = 1'b1;
        @(negedge clk);
        expect_gpio("midreset_gpio", 32'h0);
        reset = 1'b0;
        bus_read(32'h40, 32'h0, "midreset_duty0");
        bus_read(32'h04, 32'h0, "midreset_mode");
        bus_read(32'h0C, 32'h0, "midreset_status");

        @(negedge clk);
        meas("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
